// File: rtl/nes_pkg.sv
// Shared NES bus constants and the OAM DMA state encoding.
package nes_pkg;

   localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF
// into $2004, one read/write pair per byte, aligned to the bus parity.
module oam_dma
   import nes_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_d_out,
   input  logic [7:0]  bus_d_in,
   output logic        ready,
   output logic        dma_busy,
   output logic [15:0] bus_addr,
   output logic        bus_write,
   output logic [7:0]  bus_d_out
);

   dma_state_t  r_state;
   logic        r_parity;
   logic [7:0]  r_page;
   logic [7:0]  r_index;
   logic [7:0]  r_data;

   logic        w_trigger;
   logic        w_dma_owns_bus;

   assign w_trigger = cpu_write && (cpu_addr == OAMDMA_ADDR);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_parity <= 1'b0;
         r_page   <= 8'h00;
         r_index  <= 8'h00;
         r_data   <= 8'h00;
      end else begin
         r_parity <= ~r_parity;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_page  <= cpu_d_out;
                  r_index <= 8'h00;
                  r_state <= HALT;
               end
            end
            // The cycle after HALT has parity ~r_parity; reads must land on parity 0.
            HALT:  r_state <= r_parity ? READ : ALIGN;
            ALIGN: r_state <= READ;
            READ: begin
               r_data  <= bus_d_in;
               r_state <= WRITE;
            end
            WRITE: begin
               r_index <= r_index + 8'd1;
               r_state <= (r_index == 8'hFF) ? IDLE : READ;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Reset forces CPU ownership immediately so an abort never emits another DMA cycle.
   assign w_dma_owns_bus = !reset && ((r_state == READ) || (r_state == WRITE));

   assign ready    = reset || (r_state == IDLE);
   assign dma_busy = !reset && (r_state != IDLE);

   always_comb begin
      bus_addr  = cpu_addr;
      bus_write = cpu_write;
      bus_d_out = cpu_d_out;
      if (w_dma_owns_bus) begin
         if (r_state == READ) begin
            bus_addr  = {r_page, r_index};
            bus_write = 1'b0;
            bus_d_out = 8'h00;
         end else begin
            bus_addr  = OAMDATA_ADDR;
            bus_write = 1'b1;
            bus_d_out = r_data;
         end
      end
   end

endmodule
